// File: rtl/t03_pc_pkg.sv
// Shared types and constants for the team 03 program-counter generator.
package t03_pc_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned CTRL_W      = 3;
  localparam int unsigned CAUSE_W     = 2;

  typedef enum logic [CTRL_W-1:0] {
    CTRL_SEQ    = 3'b000,
    CTRL_JALR   = 3'b001,
    CTRL_BRANCH = 3'b010,
    CTRL_JAL    = 3'b011,
    CTRL_TRAP   = 3'b100,
    CTRL_RET    = 3'b101
  } pc_ctrl_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ECALL    = 2'b10
  } trap_cause_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10,
    ST_HALT = 2'b11
  } pc_state_t;

endpackage

// File: rtl/t03_pc_target.sv
// Combinational next-PC target selection and control-flow alignment check.
module t03_pc_target
  import t03_pc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic [CTRL_W-1:0] control,
  input  logic [XLEN-1:0]   currentPc,
  input  logic [XLEN-1:0]   offset,
  input  logic [XLEN-1:0]   ALUResult,
  input  logic [XLEN-1:0]   epc,
  output logic [XLEN-1:0]   target,
  output logic              misaligned
);

  pc_ctrl_t ctrl;
  assign ctrl = pc_ctrl_t'(control);

  // Unused encodings and TRAP fall back to the sequential address.
  always_comb begin
    target     = currentPc + XLEN'(INSTR_BYTES);
    misaligned = 1'b0;
    case (ctrl)
      CTRL_JALR: begin
        target     = ALUResult & ~XLEN'(1);
        misaligned = |target[ALIGN_BITS-1:0];
      end
      CTRL_BRANCH, CTRL_JAL: begin
        target     = currentPc + offset;
        misaligned = |target[ALIGN_BITS-1:0];
      end
      CTRL_RET: target = epc;
      default:  target = currentPc + XLEN'(INSTR_BYTES);
    endcase
  end

endmodule

// File: rtl/t03_pc_gen.sv
// Program-counter generator: fetch handshake, next-PC commit, trap entry/return
// and fatal double-trap halt.
module t03_pc_gen
  import t03_pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDRESS = '0,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freezePc,
  input  logic [CTRL_W-1:0]   control,
  input  logic [XLEN-1:0]     offset,
  input  logic [XLEN-1:0]     ALUResult,
  input  logic                fetchAck,
  output logic                fetchReq,
  output logic [XLEN-1:0]     currentPc,
  output logic [XLEN-1:0]     toMemory,
  output logic [XLEN-1:0]     epc,
  output logic                trapTaken,
  output logic [CAUSE_W-1:0]  trapCause,
  output logic                inTrap,
  output logic                halted
);

  pc_state_t   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  trap_cause_t cause_q, cause_d;
  logic        trap_taken_q, trap_taken_d;
  logic        fetch_req_q, fetch_req_d;
  logic        in_trap_q, in_trap_d;
  logic        halted_q, halted_d;

  logic [XLEN-1:0] target;
  logic        misaligned;
  logic        commit;
  logic        trap_hit;
  trap_cause_t trap_kind;
  pc_ctrl_t    ctrl;

  assign ctrl = pc_ctrl_t'(control);

  t03_pc_target #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target (
    .control    (control),
    .currentPc  (pc_q),
    .offset     (offset),
    .ALUResult  (ALUResult),
    .epc        (epc_q),
    .target     (target),
    .misaligned (misaligned)
  );

  assign commit    = ((state_q == ST_RUN) || (state_q == ST_TRAP)) && fetchAck && !freezePc;
  assign trap_hit  = (ctrl == CTRL_TRAP) || misaligned;
  assign trap_kind = (ctrl == CTRL_TRAP) ? CAUSE_ECALL : CAUSE_MISALIGN;

  // Next-state and register-update logic; nothing moves without a commit.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    trap_taken_d = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (commit) begin
          if (trap_hit) begin
            state_d      = ST_TRAP;
            epc_d        = pc_q;
            pc_d         = TRAP_VECTOR;
            cause_d      = trap_kind;
            trap_taken_d = 1'b1;
          end else if (ctrl == CTRL_RET) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          end else begin
            pc_d = target;
          end
        end
      end
      ST_TRAP: begin
        if (commit) begin
          // A trap inside the handler is fatal: keep epc, record the new cause.
          if (trap_hit) begin
            state_d      = ST_HALT;
            cause_d      = trap_kind;
            trap_taken_d = 1'b1;
          end else if (ctrl == CTRL_RET) begin
            state_d = ST_RUN;
            pc_d    = target;
            cause_d = CAUSE_NONE;
          end else begin
            pc_d = target;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
    fetch_req_d = (state_d == ST_RUN) || (state_d == ST_TRAP);
    in_trap_d   = (state_d == ST_TRAP);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      cause_q      <= CAUSE_NONE;
      trap_taken_q <= 1'b0;
      fetch_req_q  <= 1'b0;
      in_trap_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      trap_taken_q <= trap_taken_d;
      fetch_req_q  <= fetch_req_d;
      in_trap_q    <= in_trap_d;
      halted_q     <= halted_d;
    end
  end

  assign fetchReq  = fetch_req_q;
  assign currentPc = pc_q;
  assign toMemory  = pc_q + BASE_ADDRESS;
  assign epc       = epc_q;
  assign trapTaken = trap_taken_q;
  assign trapCause = cause_q;
  assign inTrap    = in_trap_q;
  assign halted    = halted_q;

endmodule

// File: doc/t03_pc_gen.md
# t03_pc_gen

Parametrised program-counter generator for the team 03 core; the next generation of the basic PC register. It owns the fetch address, the fetch request/acknowledge handshake and the next-PC selection: sequential, jump, branch, JALR, trap entry and trap return. It adds trap handling through an EPC register, detection of misaligned control-flow targets, and a fatal halt when a trap occurs inside a trap. It sits between the decode/ALU stage and instruction memory.

## Interface
Parameters:
- XLEN, 32, address/data width
- BASE_ADDRESS, 0, added to currentPc to form the memory address
- RESET_VECTOR, 0, currentPc value after reset
- TRAP_VECTOR, 32'h100, currentPc value on trap entry
- ALIGN_BITS, 2, low target bits that must be zero

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset; resets when 0
- freezePc  in  1  blocks any PC commit
- control  in  3  next-PC selection for the instruction at currentPc
- offset  in  XLEN  branch/JAL displacement
- ALUResult  in  XLEN  JALR target
- fetchAck  in  1  memory returned the word at toMemory
- fetchReq  out  1  fetch of toMemory requested
- currentPc  out  XLEN  address of the instruction being fetched/executed
- toMemory  out  XLEN  currentPc + BASE_ADDRESS, combinational
- epc  out  XLEN  saved PC of the trapping instruction
- trapTaken  out  1  one-cycle pulse after a trap commit
- trapCause  out  2  00 none, 01 misaligned, 10 ecall
- inTrap  out  1  handler active
- halted  out  1  fatal double trap

## Operation
- control encodings:
  - 000 SEQ: currentPc + 4
  - 001 JALR: ALUResult & ~1
  - 010 BRANCH: currentPc + offset
  - 011 JAL: currentPc + offset
  - 100 TRAP: ecall
  - 101 RET: target epc
  - 11x: treated as SEQ
- Commit condition: commit = state∈{RUN,TRAP} & fetchAck & ~freezePc. Without a commit, all registers hold.
- Misaligned target: for JALR/BRANCH/JAL, if target[ALIGN_BITS-1:0] ≠ 0:
  - trap with cause 01
  - epc ← currentPc
  - currentPc ← TRAP_VECTOR
- TRAP control: same as the misaligned trap, with cause 10.
- RET:
  - in TRAP state: currentPc ← epc, go to RUN, trapCause ← 00.
  - in RUN state: behaves as SEQ.
- States:
  - BOOT: fetchReq=0. Always goes to RUN on the next clock.
  - RUN: fetchReq=1. A trap goes to TRAP.
  - TRAP: fetchReq=1. RET goes to RUN. Any further trap, including misaligned, goes to HALT; epc is unchanged and trapCause is updated.
  - HALT: fetchReq=0, halted=1, currentPc frozen. Exits only on reset.
- Arithmetic is modulo 2^XLEN; wrap-around is silent and legal.
- epc is not checked for alignment on RET.

## Timing
- Reset values:
  - state BOOT, currentPc=RESET_VECTOR, toMemory=RESET_VECTOR+BASE_ADDRESS
  - fetchReq=0, epc=0, trapTaken=0, trapCause=00, inTrap=0, halted=0
- Reset is asynchronous, so outputs change immediately on assertion. Reset mid-fetch abandons the request with no commit.
- First fetchReq=1 appears one cycle after reset deassertion (BOOT).
- Commit latency:
  - new currentPc, toMemory, epc, state and inTrap are visible the cycle after the commit edge.
  - trapTaken is high for exactly that one cycle.
- The fetch handshake holds: toMemory is stable while fetchReq=1 and no commit occurs. Memory may hold fetchAck low indefinitely.
- fetchAck and freezePc both high: freeze wins and the acknowledge is dropped, so memory must re-acknowledge.
- fetchAck in BOOT or HALT is ignored.
- control, offset and ALUResult are sampled only at the commit edge.

## Structure
- Package t03_pc_pkg holds:
  - the pc_ctrl_t enum (SEQ, JALR, BRANCH, JAL, TRAP, RET)
  - the trap_cause_t enum
  - the pc_state_t enum (BOOT, RUN, TRAP, HALT)
  - the constant INSTR_BYTES=4
- Sub-module t03_pc_target: combinational; takes control, currentPc, offset, ALUResult and epc, and outputs target and misaligned.
- The top level holds the FSM and the registers.

## Test plan
- Reset with RESET_VECTOR=0, BASE_ADDRESS=32'h1000 -> currentPc=0 and toMemory=32'h1000 while rst=0; fetchReq rises 1 cycle after release; 3 acks with SEQ -> currentPc 4, 8, 12.
- BRANCH offset=-8 at currentPc=12, ack -> currentPc=4; freezePc=1 with ack -> no change; JALR ALUResult=32'h21 -> currentPc=32'h20.
- JAL offset=6 at currentPc=8 -> currentPc=32'h100, epc=8, trapTaken pulse 1 cycle, trapCause=01, inTrap=1; RET -> currentPc=8, inTrap=0.
- TRAP at currentPc=32'h40, then TRAP inside the handler -> halted=1, fetchReq=0, epc=32'h40, trapCause=10; later acks ignored; rst low -> all reset values.
- Wrap: currentPc=32'hFFFF_FFFC with SEQ -> currentPc=0 and no trap; control=3'b111 -> +4.
- Reset asserted while fetchReq=1 and fetchAck=0 -> immediate return to RESET_VECTOR and BOOT, no commit.
